// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared glyph codes, line layout constants and FSM state
//               encoding for the register-dump display sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Glyph codes understood by the char_bitmap plotter
    localparam logic [7:0] CHAR_R     = 8'd52;
    localparam logic [7:0] CHAR_COLON = 8'd17;
    localparam logic [7:0] CHAR_SPACE = 8'd18;

    // Line layout: "R", tens, ones, ":", " ", 8 hex nibbles
    localparam int LINE_CHARS    = 13;
    localparam int HEX_FIRST_COL = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        LATCH = 3'd3,
        EMIT  = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/disp_char_mux.sv
`default_nettype none
// ============================================================================
// Module      : disp_char_mux
// Description : Maps a column position, register index and latched register
//               value onto the glyph code shown in that cell.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_char_mux (
    input  logic [3:0]  col,
    input  logic [4:0]  index,
    input  logic [31:0] value,
    output logic [7:0]  char_code
);
    import disp_pkg::*;

    logic [1:0] w_tens;
    logic [4:0] w_ones;
    logic [2:0] w_nib_k;
    logic [3:0] w_nibble;

    // Decimal split by comparison, nibble select, then per-column glyph choice
    always_comb begin
        if (index >= 5'd30)      w_tens = 2'd3;
        else if (index >= 5'd20) w_tens = 2'd2;
        else if (index >= 5'd10) w_tens = 2'd1;
        else                     w_tens = 2'd0;

        // tens*10 formed as tens*8 + tens*2
        w_ones = index - {w_tens, 3'b000} - {2'b00, w_tens, 1'b0};

        // Columns 5..12 map to nibble k = 0..7 (wraps correctly in 3 bits);
        // nibble k sits at bit offset 4*(7-k), and 7-k is ~k in 3 bits.
        w_nib_k  = col[2:0] - 3'(HEX_FIRST_COL);
        w_nibble = value[{~w_nib_k, 2'b00} +: 4];

        case (col)
            4'd0:    char_code = CHAR_R;
            4'd1:    char_code = {6'd0, w_tens};
            4'd2:    char_code = {3'd0, w_ones};
            4'd3:    char_code = CHAR_COLON;
            4'd4:    char_code = CHAR_SPACE;
            default: char_code = {4'd0, w_nibble};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/reg_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_display_sequencer
// Description : Walks the register file over a fixed-latency read port and
//               streams one glyph request per character cell to the plotter.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_display_sequencer #(
    parameter int NUM_REGS     = 16,
    parameter int READ_LATENCY = 1,
    parameter int ROW_BASE     = 0,
    parameter int ROW_STRIDE   = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    output logic [8:0]  reg_addr,
    input  logic [31:0] register_value,
    output logic [7:0]  char_code,
    output logic [3:0]  char_col,
    output logic [5:0]  char_row,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        finished_register,
    output logic        frame_done
);
    import disp_pkg::*;

    localparam logic [4:0] c_last_index = 5'(NUM_REGS - 1);
    localparam logic [2:0] c_latency    = 3'(READ_LATENCY);
    localparam logic [3:0] c_last_col   = 4'(LINE_CHARS - 1);

    disp_state_t r_state;
    disp_state_t w_next;
    logic [4:0]  r_index;
    logic [2:0]  r_wait;
    logic [3:0]  r_col;
    logic [31:0] r_value;
    logic [8:0]  r_reg_addr;
    logic [7:0]  w_mux_code;
    logic [5:0]  w_row;
    logic        w_emit;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ADDR;
            ADDR:    w_next = (c_latency == 3'd0) ? LATCH : WAIT;
            WAIT:    if (r_wait <= 3'd1) w_next = LATCH;
            LATCH:   w_next = EMIT;
            EMIT:    if (char_ready && (r_col == c_last_col)) w_next = NEXT;
            NEXT:    w_next = (r_index == c_last_index) ? DONE : ADDR;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Register index, read address, latency counter, column and value latch
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_index    <= 5'd0;
            r_wait     <= 3'd0;
            r_col      <= 4'd0;
            r_value    <= 32'd0;
            r_reg_addr <= 9'd0;
        end else begin
            case (r_state)
                IDLE: if (start) r_index <= 5'd0;
                ADDR: begin
                    r_reg_addr <= {4'd0, r_index};
                    r_wait     <= c_latency;
                end
                WAIT: r_wait <= r_wait - 3'd1;
                LATCH: begin
                    r_value <= register_value;
                    r_col   <= 4'd0;
                end
                EMIT: if (char_ready && (r_col != c_last_col)) r_col <= r_col + 4'd1;
                NEXT: if (r_index != c_last_index) r_index <= r_index + 5'd1;
                default: ;
            endcase
        end
    end

    disp_char_mux u_char_mux (
        .col       (r_col),
        .index     (r_index),
        .value     (r_value),
        .char_code (w_mux_code)
    );

    // Output decode; character fields read as zero whenever no request is offered
    always_comb begin
        w_emit            = (r_state == EMIT);
        w_row             = 6'(ROW_BASE + int'(r_index) * ROW_STRIDE);
        char_valid        = w_emit;
        char_code         = w_emit ? w_mux_code : 8'd0;
        char_col          = w_emit ? r_col      : 4'd0;
        char_row          = w_emit ? w_row      : 6'd0;
        busy              = (r_state != IDLE);
        finished_register = (r_state == NEXT);
        frame_done        = (r_state == DONE);
        reg_addr          = r_reg_addr;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_display_sequencer
// Description : Scoreboard bench for reg_display_sequencer with a randomised
//               register file, random back-pressure and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_display_sequencer;

    localparam int NUM_REGS     = 32;
    localparam int READ_LATENCY = 3;
    localparam int ROW_BASE     = 3;
    localparam int ROW_STRIDE   = 2;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        char_ready = 1'b0;
    logic [31:0] register_value = 32'd0;
    logic [8:0]  reg_addr;
    logic [7:0]  char_code;
    logic [3:0]  char_col;
    logic [5:0]  char_row;
    logic        char_valid;
    logic        busy;
    logic        finished_register;
    logic        frame_done;

    typedef struct {
        logic [7:0] code;
        logic [3:0] col;
        logic [5:0] row;
        int         idx;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem[NUM_REGS];
    logic [8:0]  addr_pipe[READ_LATENCY];
    int          checks = 0;
    int          errors = 0;
    int          frame_no = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random
    bit          stall_once = 1'b0;
    bit          m_busy = 1'b0;
    bit          fin_exp = 1'b0;
    bit          done_exp = 1'b0;
    int          last_line = -1;

    reg_display_sequencer #(
        .NUM_REGS(NUM_REGS), .READ_LATENCY(READ_LATENCY),
        .ROW_BASE(ROW_BASE), .ROW_STRIDE(ROW_STRIDE)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .reg_addr(reg_addr),
        .register_value(register_value), .char_code(char_code), .char_col(char_col),
        .char_row(char_row), .char_valid(char_valid), .char_ready(char_ready),
        .busy(busy), .finished_register(finished_register), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference glyph for register i, column c holding value v
    function automatic logic [7:0] model_char(int i, int c, logic [31:0] v);
        case (c)
            0:       return 8'd52;
            1:       return 8'(i / 10);
            2:       return 8'(i % 10);
            3:       return 8'd17;
            4:       return 8'd18;
            default: return 8'((v >> (4 * (12 - c))) & 32'hF);
        endcase
    endfunction

    // Register file model: data appears READ_LATENCY cycles after the address
    // settles; garbage otherwise and whenever a character is being offered.
    always @(posedge clock) begin
        for (int k = 0; k < READ_LATENCY; k++)
            addr_pipe[k] <= (k == 0) ? reg_addr : addr_pipe[k-1];
    end

    always @(negedge clock) begin
        bit stable;
        stable = 1'b1;
        for (int k = 0; k < READ_LATENCY; k++)
            if (addr_pipe[k] !== reg_addr) stable = 1'b0;
        if (char_valid)  register_value <= $urandom;
        else if (stable) register_value <= mem[reg_addr[4:0]];
        else             register_value <= 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
    end

    // Back-pressure generator
    initial begin
        forever begin
            @(posedge clock); #1;
            if (stall_once && char_valid && char_col == 4'd7 && reg_addr == 9'd5) begin
                stall_once = 1'b0;
                char_ready = 1'b0;
                repeat (5) begin @(posedge clock); #1; end
                char_ready = 1'b1;
            end else if (ready_mode == 0) char_ready = 1'b1;
            else char_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares DUT outputs against the scoreboard and pulse model
    always @(negedge clock) begin
        bit   fin_n, done_n, busy_n;
        exp_t e;
        if (!resetn) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_valid", 32'(char_valid), 0);
            chk("rst_fin", 32'(finished_register), 0);
            chk("rst_done", 32'(frame_done), 0);
            chk("rst_code", 32'(char_code), 0);
            chk("rst_addr", 32'(reg_addr), 0);
            sb.delete();
            m_busy = 1'b0; fin_exp = 1'b0; done_exp = 1'b0; last_line = -1;
        end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("finished_register", 32'(finished_register), 32'(fin_exp));
            chk("frame_done", 32'(frame_done), 32'(done_exp));
            fin_n  = 1'b0;
            done_n = fin_exp && (last_line == NUM_REGS - 1);
            busy_n = done_exp ? 1'b0 : m_busy;
            if (char_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_char", 32'(char_valid), 0);
                end else begin
                    e = sb[0];
                    chk("char_code", 32'(char_code), 32'(e.code));
                    chk("char_col", 32'(char_col), 32'(e.col));
                    chk("char_row", 32'(char_row), 32'(e.row));
                    chk("reg_addr", 32'(reg_addr), 32'(e.idx));
                    if (char_ready) begin
                        void'(sb.pop_front());
                        if (e.col == 4'd12) begin
                            fin_n = 1'b1;
                            last_line = e.idx;
                        end
                    end
                end
            end
            if (start && !m_busy) begin
                busy_n = 1'b1;
                frame_no++;
                for (int i = 0; i < NUM_REGS; i++) mem[i] = $urandom;
                if (frame_no == 1) begin
                    mem[0] = 32'h0000ABCD;
                    mem[1] = 32'h12345678;
                end
                for (int i = 0; i < NUM_REGS; i++)
                    for (int c = 0; c < 13; c++) begin
                        e.code = model_char(i, c, mem[i]);
                        e.col  = 4'(c);
                        e.row  = 6'((ROW_BASE + i * ROW_STRIDE) % 64);
                        e.idx  = i;
                        sb.push_back(e);
                    end
            end
            fin_exp  = fin_n;
            done_exp = done_n;
            m_busy   = busy_n;
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while (!frame_done && n < 3000) begin tick(); n++; end
        if (!frame_done) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Frame 1: always ready, one 5-cycle stall at reg 5 col 7, ignored starts
        stall_once = 1'b1;
        pulse_start();
        repeat (40) tick();
        pulse_start();
        repeat (300) tick();
        pulse_start();
        wait_done("frame1");
        if (frame_done) begin
            start = 1'b1;   // on the frame_done cycle: ignored
            tick();         // one cycle later: starts frame 2
            tick();
            start = 1'b0;
        end

        // Frame 2: random back-pressure
        ready_mode = 1;
        repeat (2) tick();
        wait_done("frame2");
        repeat (4) tick();

        // Frame 3: reset mid-EMIT of register 4
        pulse_start();
        begin
            int n = 0;
            while (!(char_valid && reg_addr == 9'd4 && char_col == 4'd6) && n < 3000) begin
                tick(); n++;
            end
            if (n >= 3000) chk("reach_emit_timeout", 0, 1);
        end
        #2 resetn = 1'b0;
        #1;
        chk("async_valid", 32'(char_valid), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_code", 32'(char_code), 0);
        chk("async_col", 32'(char_col), 0);
        chk("async_row", 32'(char_row), 0);
        chk("async_addr", 32'(reg_addr), 0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();

        // Frame 4: full frame after reset with random back-pressure
        pulse_start();
        wait_done("frame4");
        repeat (5) tick();
        chk("scoreboard_empty", 32'(sb.size()), 0);
        chk("frames_started", 32'(frame_no), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
